// File: rtl/mem_fifo_arbiter.sv
// Arbiter for the shared DDR request path (address FIFO + write-data FIFO).
// Requester 0 (pixel feeder) issues reads and has absolute priority; requesters 1 and 2
// (line engine, fill/clear engine) issue two-beat writes and share round-robin.
// Grants cover whole transactions: a write pair is never split across grants.
`timescale 1ns/1ps
module mem_fifo_arbiter #(
   parameter int unsigned MAX_XACT = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [2:0]   req,
   output logic [2:0]   gnt,
   output logic [2:0]   fifo_access,
   // requester 0: pixel feeder (reads only)
   input  logic [30:0]  r0_af_addr_din,
   input  logic         r0_af_wr_en,
   input  logic [2:0]   r0_af_cmd,
   output logic         r0_af_full,
   // requester 1: line engine
   input  logic [30:0]  r1_af_addr_din,
   input  logic         r1_af_wr_en,
   input  logic [2:0]   r1_af_cmd,
   input  logic [127:0] r1_wdf_din,
   input  logic [15:0]  r1_wdf_mask_din,
   input  logic         r1_wdf_wr_en,
   output logic         r1_af_full,
   output logic         r1_wdf_full,
   // requester 2: fill/clear engine
   input  logic [30:0]  r2_af_addr_din,
   input  logic         r2_af_wr_en,
   input  logic [2:0]   r2_af_cmd,
   input  logic [127:0] r2_wdf_din,
   input  logic [15:0]  r2_wdf_mask_din,
   input  logic         r2_wdf_wr_en,
   output logic         r2_af_full,
   output logic         r2_wdf_full,
   // shared FIFO interface
   input  logic         af_full,
   input  logic         wdf_full,
   output logic [30:0]  af_addr_din,
   output logic [2:0]   af_cmd_din,
   output logic         af_wr_en,
   output logic [127:0] wdf_din,
   output logic [15:0]  wdf_mask_din,
   output logic         wdf_wr_en
);

   localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_XACT);
   localparam logic [2:0]       CmdWrite = 3'b000;

   typedef enum logic [1:0] {StIdle, StGrant, StDrain} state_e;

   state_e           state_q, state_d;
   logic [2:0]       gnt_q, gnt_d;
   logic [2:0]       fifo_access_q;
   logic [1:0]       rr_ptr_q, rr_ptr_d;    // writer preferred on the next 1-vs-2 tie
   logic [CNT_W-1:0] xact_cnt_q, xact_cnt_d;
   logic             beat_pending_q, beat_pending_d;

   logic af_acc, wdf_acc, writer_gnt, req_held, rel_cond;

   assign gnt         = gnt_q;
   assign fifo_access = fifo_access_q;

   // Mux the granted requester onto the shared FIFO inputs; idle values when ungranted.
   always_comb begin
      af_addr_din  = '0;
      af_cmd_din   = '0;
      af_wr_en     = 1'b0;
      wdf_din      = '0;
      wdf_mask_din = '1;
      wdf_wr_en    = 1'b0;
      if (gnt_q[0]) begin
         af_addr_din = r0_af_addr_din;
         af_cmd_din  = r0_af_cmd;
         af_wr_en    = r0_af_wr_en;
      end
      if (gnt_q[1]) begin
         af_addr_din  = r1_af_addr_din;
         af_cmd_din   = r1_af_cmd;
         af_wr_en     = r1_af_wr_en;
         wdf_din      = r1_wdf_din;
         wdf_mask_din = r1_wdf_mask_din;
         wdf_wr_en    = r1_wdf_wr_en;
      end
      if (gnt_q[2]) begin
         af_addr_din  = r2_af_addr_din;
         af_cmd_din   = r2_af_cmd;
         af_wr_en     = r2_af_wr_en;
         wdf_din      = r2_wdf_din;
         wdf_mask_din = r2_wdf_mask_din;
         wdf_wr_en    = r2_wdf_wr_en;
      end
   end

   // Per-requester backpressure; DRAIN blocks new addresses while the pair completes.
   always_comb begin
      r0_af_full  = af_full | ~gnt_q[0] | (state_q == StDrain);
      r1_af_full  = af_full | ~gnt_q[1] | (state_q == StDrain);
      r2_af_full  = af_full | ~gnt_q[2] | (state_q == StDrain);
      r1_wdf_full = wdf_full | ~gnt_q[1];
      r2_wdf_full = wdf_full | ~gnt_q[2];
   end

   assign af_acc     = af_wr_en & ~af_full;
   assign wdf_acc    = wdf_wr_en & ~wdf_full;
   assign writer_gnt = gnt_q[1] | gnt_q[2];
   assign req_held   = |(req & gnt_q);

   // Next-state: grant selection, transaction counting, pair tracking and release.
   // Release decisions use this cycle's updated count/pending so an accepted 16th
   // transaction or a completing beat takes effect without an extra cycle.
   always_comb begin
      state_d        = state_q;
      gnt_d          = gnt_q;
      rr_ptr_d       = rr_ptr_q;
      xact_cnt_d     = xact_cnt_q;
      beat_pending_d = beat_pending_q;
      rel_cond       = 1'b0;
      unique case (state_q)
         StIdle: begin
            xact_cnt_d     = '0;
            beat_pending_d = 1'b0;
            if (req[0]) begin
               gnt_d   = 3'b001;
               state_d = StGrant;
            end else if (req[1] && req[2]) begin
               gnt_d   = (rr_ptr_q == 2'd2) ? 3'b100 : 3'b010;
               state_d = StGrant;
            end else if (req[1]) begin
               gnt_d   = 3'b010;
               state_d = StGrant;
            end else if (req[2]) begin
               gnt_d   = 3'b100;
               state_d = StGrant;
            end
         end
         StGrant: begin
            if (af_acc && (xact_cnt_q != MaxCnt)) begin
               xact_cnt_d = xact_cnt_q + CNT_W'(1);
            end
            if (!beat_pending_q) begin
               beat_pending_d = af_acc && (af_cmd_din == CmdWrite) && wdf_acc;
            end else if (wdf_acc) begin
               beat_pending_d = 1'b0;
            end
            rel_cond = !req_held || (xact_cnt_d == MaxCnt) ||
                       (req[0] && writer_gnt && (xact_cnt_d != '0));
            if (rel_cond) begin
               if (beat_pending_d) begin
                  state_d = StDrain;
               end else begin
                  state_d    = StIdle;
                  gnt_d      = '0;
                  xact_cnt_d = '0;
                  if (gnt_q[1]) rr_ptr_d = 2'd2;
                  else if (gnt_q[2]) rr_ptr_d = 2'd1;
               end
            end
         end
         StDrain: begin
            if (wdf_acc) begin
               beat_pending_d = 1'b0;
               state_d        = StIdle;
               gnt_d          = '0;
               xact_cnt_d     = '0;
               if (gnt_q[1]) rr_ptr_d = 2'd2;
               else if (gnt_q[2]) rr_ptr_d = 2'd1;
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         gnt_q          <= '0;
         fifo_access_q  <= '0;
         rr_ptr_q       <= 2'd1;
         xact_cnt_q     <= '0;
         beat_pending_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         gnt_q          <= gnt_d;
         fifo_access_q  <= gnt_d;
         rr_ptr_q       <= rr_ptr_d;
         xact_cnt_q     <= xact_cnt_d;
         beat_pending_q <= beat_pending_d;
      end
   end

endmodule

// File: tb/tb_mem_fifo_arbiter.sv
// Self-checking bench for mem_fifo_arbiter: scenario tasks plus a scoreboard that
// matches every accepted shared-FIFO write against queued expectations.
`timescale 1ns/1ps
module tb_mem_fifo_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   req;
   logic [2:0]   gnt, fifo_access;
   logic [30:0]  r0_af_addr_din, r1_af_addr_din, r2_af_addr_din;
   logic         r0_af_wr_en, r1_af_wr_en, r2_af_wr_en;
   logic [2:0]   r0_af_cmd, r1_af_cmd, r2_af_cmd;
   logic [127:0] r1_wdf_din, r2_wdf_din;
   logic [15:0]  r1_wdf_mask_din, r2_wdf_mask_din;
   logic         r1_wdf_wr_en, r2_wdf_wr_en;
   logic         r0_af_full, r1_af_full, r2_af_full, r1_wdf_full, r2_wdf_full;
   logic         af_full, wdf_full;
   logic [30:0]  af_addr_din;
   logic [2:0]   af_cmd_din;
   logic         af_wr_en;
   logic [127:0] wdf_din;
   logic [15:0]  wdf_mask_din;
   logic         wdf_wr_en;

   int n_checks = 0;
   int n_fail   = 0;

   logic [33:0]  af_q[$];    // {addr, cmd}
   logic [143:0] wdf_q[$];   // {data, mask}
   logic [33:0]  af_exp;
   logic [143:0] wdf_exp;

   always #5 clk = ~clk;

   mem_fifo_arbiter #(.MAX_XACT(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt), .fifo_access(fifo_access),
      .r0_af_addr_din(r0_af_addr_din), .r0_af_wr_en(r0_af_wr_en), .r0_af_cmd(r0_af_cmd),
      .r0_af_full(r0_af_full),
      .r1_af_addr_din(r1_af_addr_din), .r1_af_wr_en(r1_af_wr_en), .r1_af_cmd(r1_af_cmd),
      .r1_wdf_din(r1_wdf_din), .r1_wdf_mask_din(r1_wdf_mask_din),
      .r1_wdf_wr_en(r1_wdf_wr_en), .r1_af_full(r1_af_full), .r1_wdf_full(r1_wdf_full),
      .r2_af_addr_din(r2_af_addr_din), .r2_af_wr_en(r2_af_wr_en), .r2_af_cmd(r2_af_cmd),
      .r2_wdf_din(r2_wdf_din), .r2_wdf_mask_din(r2_wdf_mask_din),
      .r2_wdf_wr_en(r2_wdf_wr_en), .r2_af_full(r2_af_full), .r2_wdf_full(r2_wdf_full),
      .af_full(af_full), .wdf_full(wdf_full),
      .af_addr_din(af_addr_din), .af_cmd_din(af_cmd_din), .af_wr_en(af_wr_en),
      .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en)
   );

   // Scoreboard: compare each accepted shared-FIFO write, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst && af_wr_en && !af_full) begin
         n_checks = n_checks + 1;
         if (af_q.size() == 0) begin
            n_fail = n_fail + 1;
            $display("FAIL af_unexpected: got addr %h cmd %b, required no write", af_addr_din,
                     af_cmd_din);
         end else begin
            af_exp = af_q.pop_front();
            if ({af_addr_din, af_cmd_din} !== af_exp) begin
               n_fail = n_fail + 1;
               $display("FAIL af_data: got %h/%b, required %h/%b", af_addr_din, af_cmd_din,
                        af_exp[33:3], af_exp[2:0]);
            end
         end
      end
      if (!rst && wdf_wr_en && !wdf_full) begin
         n_checks = n_checks + 1;
         if (wdf_q.size() == 0) begin
            n_fail = n_fail + 1;
            $display("FAIL wdf_unexpected: got data %h mask %h, required no write", wdf_din,
                     wdf_mask_din);
         end else begin
            wdf_exp = wdf_q.pop_front();
            if ({wdf_din, wdf_mask_din} !== wdf_exp) begin
               n_fail = n_fail + 1;
               $display("FAIL wdf_data: got %h/%h, required %h/%h", wdf_din, wdf_mask_din,
                        wdf_exp[143:16], wdf_exp[15:0]);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required test completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req = 3'b000; af_full = 1'b0; wdf_full = 1'b0;
      r0_af_addr_din = '0; r0_af_wr_en = 1'b0; r0_af_cmd = 3'b001;
      r1_af_addr_din = '0; r1_af_wr_en = 1'b0; r1_af_cmd = 3'b000;
      r2_af_addr_din = '0; r2_af_wr_en = 1'b0; r2_af_cmd = 3'b000;
      r1_wdf_din = '0; r1_wdf_mask_din = '0; r1_wdf_wr_en = 1'b0;
      r2_wdf_din = '0; r2_wdf_mask_din = '0; r2_wdf_wr_en = 1'b0;
   endtask

   // Drive one write beat on requester n (and the address when with_af), queue expectations.
   task automatic drive_beat(input int n, input bit with_af, input logic [30:0] a,
                             input bit push);
      logic [127:0] d;
      logic [15:0]  m;
      d = {$urandom, $urandom, $urandom, $urandom};
      m = 16'($urandom);
      if (n == 1) begin
         r1_af_addr_din = a; r1_af_cmd = 3'b000; r1_af_wr_en = with_af;
         r1_wdf_din = d; r1_wdf_mask_din = m; r1_wdf_wr_en = 1'b1;
      end else begin
         r2_af_addr_din = a; r2_af_cmd = 3'b000; r2_af_wr_en = with_af;
         r2_wdf_din = d; r2_wdf_mask_din = m; r2_wdf_wr_en = 1'b1;
      end
      if (with_af) af_q.push_back({a, 3'b000});
      if (push) wdf_q.push_back({d, m});
   endtask

   task automatic clear_writers();
      r1_af_wr_en = 1'b0; r1_wdf_wr_en = 1'b0;
      r2_af_wr_en = 1'b0; r2_wdf_wr_en = 1'b0;
   endtask

   task automatic wr_pair(input int n, input logic [30:0] a);
      drive_beat(n, 1'b1, a, 1'b1);
      step();
      drive_beat(n, 1'b0, a, 1'b1);
      step();
      clear_writers();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      n_checks = n_checks + 4;
      if ({gnt, fifo_access} !== 6'b000000) begin
         n_fail = n_fail + 1;
         $display("FAIL reset_gnt: got %b/%b, required 000/000", gnt, fifo_access);
      end
      if ({af_wr_en, wdf_wr_en, af_addr_din, af_cmd_din} !== 36'd0) begin
         n_fail = n_fail + 1;
         $display("FAIL reset_af: got en %b%b addr %h cmd %b, required all zero", af_wr_en,
                  wdf_wr_en, af_addr_din, af_cmd_din);
      end
      if ({wdf_din, wdf_mask_din} !== {128'd0, 16'hFFFF}) begin
         n_fail = n_fail + 1;
         $display("FAIL reset_wdf: got %h/%h, required 0/ffff", wdf_din, wdf_mask_din);
      end
      if ({r0_af_full, r1_af_full, r2_af_full, r1_wdf_full, r2_wdf_full} !== 5'b11111) begin
         n_fail = n_fail + 1;
         $display("FAIL reset_full: got %b%b%b%b%b, required 11111", r0_af_full, r1_af_full,
                  r2_af_full, r1_wdf_full, r2_wdf_full);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_writer();
      req = 3'b010;
      step();
      n_checks = n_checks + 2;
      if ({gnt, fifo_access} !== 6'b010010) begin
         n_fail = n_fail + 1;
         $display("FAIL single_gnt: got %b/%b, required 010/010", gnt, fifo_access);
      end
      if ({r0_af_full, r1_af_full, r2_af_full} !== 3'b101) begin
         n_fail = n_fail + 1;
         $display("FAIL single_af_full: got %b%b%b, required 101", r0_af_full, r1_af_full,
                  r2_af_full);
      end
      wr_pair(1, 31'h0000_1000);
      wr_pair(1, 31'h0000_1010);
      req = 3'b000;
      step();
      n_checks = n_checks + 1;
      if (gnt !== 3'b000) begin
         n_fail = n_fail + 1;
         $display("FAIL single_release: got %b, required 000", gnt);
      end
   endtask

   task automatic test_round_robin();
      // Requester 1 released last, so requester 2 wins the tie.
      req = 3'b110;
      step();
      n_checks = n_checks + 1;
      if (gnt !== 3'b100) begin
         n_fail = n_fail + 1;
         $display("FAIL rr_first: got %b, required 100", gnt);
      end
      req = 3'b010;
      step();
      n_checks = n_checks + 1;
      if (gnt !== 3'b000) begin
         n_fail = n_fail + 1;
         $display("FAIL rr_bubble: got %b, required 000", gnt);
      end
      step();
      n_checks = n_checks + 1;
      if (gnt !== 3'b010) begin
         n_fail = n_fail + 1;
         $display("FAIL rr_second: got %b, required 010", gnt);
      end
      req = 3'b000;
      step();
      req = 3'b110;
      step();
      n_checks = n_checks + 1;
      if (gnt !== 3'b100) begin
         n_fail = n_fail + 1;
         $display("FAIL rr_prefer2: got %b, required 100", gnt);
      end
      req = 3'b000;
      step();
      step();
   endtask

   task automatic test_preempt_drain();
      logic [30:0] a;
      req = 3'b010;
      step();
      a = 31'h0000_2000;
      drive_beat(1, 1'b1, a, 1'b1);
      step();
      // Second beat stalled by wdf_full for three cycles while req[0] rises.
      req = 3'b011; wdf_full = 1'b1;
      drive_beat(1, 1'b0, a, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks = n_checks + 1;
         if ({gnt, r1_af_full, r1_wdf_full} !== 5'b01011) begin
            n_fail = n_fail + 1;
            $display("FAIL drain_hold%0d: got gnt %b af_full %b wdf_full %b, required 010 1 1",
                     i, gnt, r1_af_full, r1_wdf_full);
         end
      end
      step();
      wdf_full = 1'b0;
      wdf_q.push_back({r1_wdf_din, r1_wdf_mask_din});
      n_checks = n_checks + 1;
      if (gnt !== 3'b010) begin
         n_fail = n_fail + 1;
         $display("FAIL drain_last: got %b, required 010", gnt);
      end
      step();
      clear_writers();
      req = 3'b001;
      n_checks = n_checks + 1;
      if (gnt !== 3'b000) begin
         n_fail = n_fail + 1;
         $display("FAIL drain_release: got %b, required 000", gnt);
      end
      step();
      n_checks = n_checks + 1;
      if ({gnt, r0_af_full} !== 4'b0010) begin
         n_fail = n_fail + 1;
         $display("FAIL preempt_gnt: got %b af_full %b, required 001 0", gnt, r0_af_full);
      end
      r0_af_addr_din = 31'h0000_3000; r0_af_cmd = 3'b001; r0_af_wr_en = 1'b1;
      af_q.push_back({31'h0000_3000, 3'b001});
      step();
      r0_af_wr_en = 1'b0;
      req = 3'b000;
      step();
   endtask

   task automatic test_max_xact();
      int issued;
      req = 3'b010;
      step();
      req = 3'b110;
      issued = 0;
      for (int i = 0; i < 20; i++) begin
         if (r1_af_full) break;
         wr_pair(1, 31'h0001_0000 + 31'(i * 16));
         issued = issued + 1;
      end
      n_checks = n_checks + 2;
      if (issued !== 16) begin
         n_fail = n_fail + 1;
         $display("FAIL max_count: got %0d, required 16", issued);
      end
      if (gnt !== 3'b000) begin
         n_fail = n_fail + 1;
         $display("FAIL max_gap: got %b, required 000", gnt);
      end
      step();
      n_checks = n_checks + 1;
      if (gnt !== 3'b100) begin
         n_fail = n_fail + 1;
         $display("FAIL max_next: got %b, required 100", gnt);
      end
      req = 3'b010;
      step();
      step();
      n_checks = n_checks + 1;
      if (gnt !== 3'b010) begin
         n_fail = n_fail + 1;
         $display("FAIL max_regrant: got %b, required 010", gnt);
      end
      req = 3'b000;
      step();
   endtask

   task automatic test_af_full();
      req = 3'b100;
      step();
      af_full = 1'b1;
      r2_af_addr_din = 31'h0000_4000; r2_af_cmd = 3'b001; r2_af_wr_en = 1'b1;
      step();
      n_checks = n_checks + 1;
      if ({r0_af_full, r1_af_full, r2_af_full, af_wr_en} !== 4'b1111) begin
         n_fail = n_fail + 1;
         $display("FAIL af_full_status: got %b%b%b en %b, required 111 1", r0_af_full,
                  r1_af_full, r2_af_full, af_wr_en);
      end
      // No accepted transaction yet, so req[0] may not preempt.
      req = 3'b101;
      step();
      step();
      n_checks = n_checks + 1;
      if (gnt !== 3'b100) begin
         n_fail = n_fail + 1;
         $display("FAIL af_full_no_count: got %b, required 100", gnt);
      end
      af_full = 1'b0;
      af_q.push_back({31'h0000_4000, 3'b001});
      step();
      r2_af_wr_en = 1'b0;
      n_checks = n_checks + 1;
      if (gnt !== 3'b000) begin
         n_fail = n_fail + 1;
         $display("FAIL af_full_preempt: got %b, required 000", gnt);
      end
      step();
      n_checks = n_checks + 1;
      if (gnt !== 3'b001) begin
         n_fail = n_fail + 1;
         $display("FAIL af_full_gnt0: got %b, required 001", gnt);
      end
      req = 3'b000;
      step();
   endtask

   task automatic test_reset_mid();
      req = 3'b010;
      step();
      drive_beat(1, 1'b1, 31'h0000_5000, 1'b1);
      step();
      clear_writers();
      rst = 1'b1;
      step();
      r1_wdf_wr_en = 1'b1;
      #1;
      n_checks = n_checks + 1;
      if ({gnt, fifo_access, af_wr_en, wdf_wr_en, wdf_mask_din} !== {8'h00, 16'hFFFF}) begin
         n_fail = n_fail + 1;
         $display("FAIL reset_mid: got gnt %b acc %b en %b%b mask %h, required 0 0 00 ffff",
                  gnt, fifo_access, af_wr_en, wdf_wr_en, wdf_mask_din);
      end
      rst = 1'b0;
      r1_wdf_wr_en = 1'b0;
      step();
      n_checks = n_checks + 1;
      if (gnt !== 3'b010) begin
         n_fail = n_fail + 1;
         $display("FAIL reset_regrant: got %b, required 010", gnt);
      end
      // Pending pair was abandoned, so dropping req releases at once.
      req = 3'b000;
      step();
      n_checks = n_checks + 1;
      if (gnt !== 3'b000) begin
         n_fail = n_fail + 1;
         $display("FAIL reset_no_drain: got %b, required 000", gnt);
      end
   endtask

   initial begin
      test_reset();
      test_single_writer();
      test_round_robin();
      test_preempt_drain();
      test_max_xact();
      test_af_full();
      test_reset_mid();
      step();
      n_checks = n_checks + 2;
      if (af_q.size() != 0) begin
         n_fail = n_fail + 1;
         $display("FAIL af_leftover: got %0d queued, required 0", af_q.size());
      end
      if (wdf_q.size() != 0) begin
         n_fail = n_fail + 1;
         $display("FAIL wdf_leftover: got %0d queued, required 0", wdf_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_fifo_arbiter.md
Name: mem_fifo_arbiter

Overview:
- Shares the single DDR request path among three requesters: pixel feeder (req 0, reads), line engine (req 1, writes), and fill/clear engine (req 2, writes).
- The request path is the address FIFO (af) and the write-data FIFO (wdf).
- Grants whole transactions, never splitting a two-beat write.
- Muxes the granted requester's FIFO signals onto the shared FIFO inputs and returns per-requester full/grant status.

Parameters:
- MAX_XACT, 16: maximum af transactions one requester may issue per grant before forced release.
- CNT_W, 5: width of the transaction counter; must hold MAX_XACT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req[2:0]  in  3  per-requester access request, held until done
- gnt[2:0]  out  3  one-hot grant
- fifo_access[2:0]  out  3  registered copy of gnt, for debug/chipscope
- rN_af_addr_din  in  31  requester N address (N=0..2)
- rN_af_wr_en  in  1  requester N address write
- rN_af_cmd  in  3  requester N command (000 write, 001 read)
- rN_wdf_din  in  128  requester N write data (N=1,2 only)
- rN_wdf_mask_din  in  16  requester N write mask (N=1,2 only)
- rN_wdf_wr_en  in  1  requester N data write (N=1,2 only)
- rN_af_full  out  1  af_full OR NOT gnt[N]
- rN_wdf_full  out  1  wdf_full OR NOT gnt[N] (N=1,2)
- af_full  in  1  shared address FIFO full
- wdf_full  in  1  shared write-data FIFO full
- af_addr_din  out  31  muxed address
- af_cmd_din  out  3  muxed command
- af_wr_en  out  1  muxed address write
- wdf_din  out  128  muxed write data
- wdf_mask_din  out  16  muxed write mask
- wdf_wr_en  out  1  muxed data write

Behaviour:
- Reset values:
  - gnt=0, fifo_access=0.
  - af_wr_en=0, wdf_wr_en=0.
  - af_addr_din=0, af_cmd_din=0, wdf_din=0, wdf_mask_din=16'hFFFF.
  - State IDLE, rr_ptr=1, xact_cnt=0, beat_pending=0.
- Output path:
  - Outputs are combinational muxes selected by the registered gnt.
  - af_wr_en = OR over N of (gnt[N] AND rN_af_wr_en). wdf_wr_en is built the same way.
  - With no grant: enables are 0 and mask is FFFF.
  - An enable forwarded while the shared FIFO is full is the requester's error; the arbiter does not gate it.
- States: IDLE, GRANT, DRAIN.
- IDLE:
  - If req[0], grant requester 0; otherwise round-robin between req[1] and req[2], starting at rr_ptr.
  - Any grant moves to GRANT the next cycle, with gnt registered.
  - Zero-cycle gap: a request seen in cycle t gives gnt high at t+1.
- GRANT:
  - xact_cnt increments on each forwarded af_wr_en with af_full=0.
  - beat_pending tracks the write pair:
    - Set on a forwarded write command (cmd 000) accepted together with a wdf beat.
    - Cleared on the second wdf beat accepted with wdf_full=0.
  - Release when:
    - req[gnt] falls and beat_pending=0; or
    - xact_cnt==MAX_XACT and beat_pending=0; or
    - req[0] is high while a writer holds the grant, xact_cnt>=1 and beat_pending=0 (pixel preemption).
  - Release goes to IDLE: gnt=0 for one cycle, xact_cnt=0, and rr_ptr set to the other writer if the releasing requester was a writer.
  - If a release condition is met while beat_pending=1, go to DRAIN.
- DRAIN:
  - Grant is held; rN_af_full is forced 1 for the granted requester.
  - On the completing wdf beat, go to IDLE.
- Requester 0 has no wdf; its beat_pending is always 0.
- Drop of req with no transaction issued releases immediately, with no minimum hold.
- Simultaneous release and new request: the one-cycle IDLE bubble is mandatory, which guarantees gnt never changes while enables are in flight.
- Reset mid-transaction: everything returns to reset values next edge. The partially written pair is abandoned; the memory controller FIFOs are reset by the same rst.
- xact_cnt saturates at MAX_XACT.

Test Plan:
- req=3'b010; line engine issues 2 write pairs, then drops req -> gnt=010 at t+1; af_wr_en pulses 2, wdf_wr_en pulses 4 with matching data/mask; gnt=000 the cycle after req drops.
- req=3'b110 simultaneously from IDLE -> gnt=100 first; after req[2] drops, gnt=010; rr_ptr then prefers 2 on the next tie.
- Writer 1 holds grant; req[0] rises while beat_pending=1 and wdf_full=1 for 3 cycles -> grant held in DRAIN; r1_af_full=1; release only after the second beat lands; gnt=001 two cycles later.
- req[1] held continuously, MAX_XACT=16 -> exactly 16 af writes, forced release; 1-cycle gap; req[2] pending gets the grant, else req[1] is regranted.
- af_full=1 during grant to requester 2 -> r2_af_full=1, r1_af_full=1 (ungranted); xact_cnt does not advance.
- rst asserted with beat_pending=1 -> next cycle gnt=0, enables 0, mask FFFF, state IDLE.
